// File: rtl/safety_island_periph_demux_if.sv
// Register-bus bundle between the safety-island core data port, the peripheral
// demux and its target slots. The slave modport is the demux view of the bundle.
interface safety_island_periph_demux_if #(
    parameter int unsigned NumPeriphs = 7,
    parameter int unsigned DataWidth  = 32
);
    logic                            req_i;
    logic [31:0]                     addr_i;
    logic                            we_i;
    logic [DataWidth/8-1:0]          be_i;
    logic [DataWidth-1:0]            wdata_i;
    logic                            gnt_o;
    logic                            rvalid_o;
    logic [DataWidth-1:0]            rdata_o;
    logic                            err_o;
    logic [NumPeriphs-1:0]           periph_req_o;
    logic [31:0]                     periph_addr_o;
    logic                            periph_we_o;
    logic [DataWidth/8-1:0]          periph_be_o;
    logic [DataWidth-1:0]            periph_wdata_o;
    logic [NumPeriphs-1:0]           periph_gnt_i;
    logic [NumPeriphs-1:0]           periph_rvalid_i;
    logic [NumPeriphs*DataWidth-1:0] periph_rdata_i;
    logic [NumPeriphs-1:0]           periph_err_i;
    logic                            timeout_o;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output periph_req_o, periph_addr_o, periph_we_o, periph_be_o, periph_wdata_o,
        input  periph_gnt_i, periph_rvalid_i, periph_rdata_i, periph_err_i,
        output timeout_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  periph_req_o, periph_addr_o, periph_we_o, periph_be_o, periph_wdata_o,
        output periph_gnt_i, periph_rvalid_i, periph_rdata_i, periph_err_i,
        input  timeout_o
    );
endinterface

// File: rtl/safety_island_periph_demux.sv
// Single-outstanding demux from the safety-island core data port to its peripheral
// targets, with an internal error slave for unmapped accesses and stalled targets.
module safety_island_periph_demux #(
    parameter int unsigned          NumPeriphs    = 7,
    parameter logic [31:0]          BaseAddr      = 32'h0000_0000,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          TimeoutCycles = 1024,
    parameter logic [DataWidth-1:0] ErrData       = DataWidth'(32'hBADC_AB1E)
) (
    input logic                          clk_i,
    input logic                          rst_i,
    safety_island_periph_demux_if.slave  bus
);

    localparam int unsigned SelW = $clog2(NumPeriphs);
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } state_e;

    state_e          state_q, state_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0]           off;
    logic [SelW-1:0]       dec_slot;
    logic                  gnt;
    logic                  rvalid;
    logic [DataWidth-1:0]  rdata;
    logic                  err;
    logic                  timeout;
    logic [NumPeriphs-1:0] req_vec;

    // Address map; slot 0 means unmapped and is served by the internal error slave.
    always_comb begin
        off      = bus.addr_i - BaseAddr;
        dec_slot = '0;
        if (bus.addr_i >= BaseAddr) begin
            if (off < 32'h0000_1000)                               dec_slot = SelW'(1);
            else if (off < 32'h0000_2000)                          dec_slot = SelW'(2);
            else if (off < 32'h0000_3000)                          dec_slot = SelW'(3);
            else if (off < 32'h0000_4000)                          dec_slot = SelW'(4);
            else if (off >= 32'h0000_6000 && off < 32'h0000_7000) begin
                if (NumPeriphs >= 7)                               dec_slot = SelW'(6);
            end
            else if (off >= 32'h0000_7000 && off < 32'h0003_7000)  dec_slot = SelW'(5);
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        timeout = 1'b0;
        req_vec = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    if (dec_slot != '0) begin
                        req_vec[dec_slot] = 1'b1;
                        gnt               = bus.periph_gnt_i[dec_slot];
                        if (gnt) begin
                            sel_d   = dec_slot;
                            cnt_d   = '0;
                            state_d = WAIT;
                        end
                    end else begin
                        gnt     = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                rvalid  = 1'b1;
                err     = 1'b1;
                rdata   = ErrData;
                state_d = IDLE;
            end
            WAIT: begin
                // A real response beats a timeout that lands in the same cycle.
                if (bus.periph_rvalid_i[sel_q]) begin
                    rvalid  = 1'b1;
                    rdata   = bus.periph_rdata_i[int'(sel_q)*DataWidth +: DataWidth];
                    err     = bus.periph_err_i[sel_q];
                    state_d = IDLE;
                end else if (cnt_q == CntLast) begin
                    rvalid  = 1'b1;
                    err     = 1'b1;
                    rdata   = ErrData;
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything the block drives is forced quiet while reset is held.
    assign bus.gnt_o          = gnt & ~rst_i;
    assign bus.rvalid_o       = rvalid & ~rst_i;
    assign bus.rdata_o        = rst_i ? '0 : rdata;
    assign bus.err_o          = err & ~rst_i;
    assign bus.timeout_o      = timeout & ~rst_i;
    assign bus.periph_req_o   = rst_i ? '0 : req_vec;
    assign bus.periph_addr_o  = rst_i ? '0 : bus.addr_i;
    assign bus.periph_we_o    = bus.we_i & ~rst_i;
    assign bus.periph_be_o    = rst_i ? '0 : bus.be_i;
    assign bus.periph_wdata_o = rst_i ? '0 : bus.wdata_i;

endmodule

// File: tb/tb_safety_island_periph_demux.sv
// Bench for safety_island_periph_demux: a 7-slot and a 6-slot instance share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_safety_island_periph_demux;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hBADC_AB1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [6:0]  pgnt;
    logic [6:0]  prvalid;
    logic [6:0]  perr;
    logic [223:0] prdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    safety_island_periph_demux_if #(.NumPeriphs(7), .DataWidth(32)) if7 ();
    safety_island_periph_demux_if #(.NumPeriphs(6), .DataWidth(32)) if6 ();

    safety_island_periph_demux #(.NumPeriphs(7), .TimeoutCycles(TIMEOUT)) dut7 (
        .clk_i(clk), .rst_i(rst), .bus(if7)
    );
    safety_island_periph_demux #(.NumPeriphs(6), .TimeoutCycles(TIMEOUT)) dut6 (
        .clk_i(clk), .rst_i(rst), .bus(if6)
    );

    assign if7.req_i = req;   assign if6.req_i = req;
    assign if7.addr_i = addr; assign if6.addr_i = addr;
    assign if7.we_i = we;     assign if6.we_i = we;
    assign if7.be_i = be;     assign if6.be_i = be;
    assign if7.wdata_i = wdata;
    assign if6.wdata_i = wdata;
    assign if7.periph_gnt_i    = pgnt;
    assign if6.periph_gnt_i    = pgnt[5:0];
    assign if7.periph_rvalid_i = prvalid;
    assign if6.periph_rvalid_i = prvalid[5:0];
    assign if7.periph_err_i    = perr;
    assign if6.periph_err_i    = perr[5:0];
    assign if7.periph_rdata_i  = prdata;
    assign if6.periph_rdata_i  = prdata[191:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Address map as a range table; n is the slot count of the instance.
    function automatic int model_slot(input logic [31:0] a, input int n);
        logic [31:0] lo [6];
        logic [31:0] hi [6];
        int          id [6];
        lo[0] = 32'h0000; hi[0] = 32'h1000;  id[0] = 1;
        lo[1] = 32'h1000; hi[1] = 32'h2000;  id[1] = 2;
        lo[2] = 32'h2000; hi[2] = 32'h3000;  id[2] = 3;
        lo[3] = 32'h3000; hi[3] = 32'h4000;  id[3] = 4;
        lo[4] = 32'h6000; hi[4] = 32'h7000;  id[4] = 6;
        lo[5] = 32'h7000; hi[5] = 32'h37000; id[5] = 5;
        for (int i = 0; i < 6; i++)
            if (a >= lo[i] && a < hi[i] && id[i] < n) return id[i];
        return 0;
    endfunction

    // Model: one outstanding transaction per instance, tracked by the cycle it was granted.
    int   cyc = 0;
    bit   busy [2];
    bit   errn [2];
    int   slot_m [2];
    int   start_m [2];
    int   n_m, s_m;
    logic [6:0]  a_req, e_req;
    logic        a_gnt, a_rv, a_err, a_to, a_we, e_gnt, e_rv, e_err, e_to;
    logic [31:0] a_rd, a_addr, a_wd, e_rd;
    logic [3:0]  a_be;
    string       tag;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            n_m = (k == 0) ? 7 : 6;
            if (k == 0) begin
                a_req = if7.periph_req_o; a_gnt = if7.gnt_o; a_rv = if7.rvalid_o;
                a_rd = if7.rdata_o; a_err = if7.err_o; a_to = if7.timeout_o;
                a_addr = if7.periph_addr_o; a_we = if7.periph_we_o;
                a_be = if7.periph_be_o; a_wd = if7.periph_wdata_o;
            end else begin
                a_req = {1'b0, if6.periph_req_o}; a_gnt = if6.gnt_o; a_rv = if6.rvalid_o;
                a_rd = if6.rdata_o; a_err = if6.err_o; a_to = if6.timeout_o;
                a_addr = if6.periph_addr_o; a_we = if6.periph_we_o;
                a_be = if6.periph_be_o; a_wd = if6.periph_wdata_o;
            end
            e_req = '0; e_gnt = 1'b0; e_rv = 1'b0; e_rd = '0; e_err = 1'b0; e_to = 1'b0;
            if (rst) begin
                busy[k] = 1'b0;
                errn[k] = 1'b0;
            end else if (errn[k]) begin
                e_rv = 1'b1; e_err = 1'b1; e_rd = ERR_DATA;
                errn[k] = 1'b0;
            end else if (busy[k]) begin
                if (prvalid[slot_m[k]]) begin
                    e_rv = 1'b1; e_rd = prdata[slot_m[k]*32 +: 32]; e_err = perr[slot_m[k]];
                    busy[k] = 1'b0;
                end else if (cyc - start_m[k] == TIMEOUT) begin
                    e_rv = 1'b1; e_err = 1'b1; e_rd = ERR_DATA; e_to = 1'b1;
                    busy[k] = 1'b0;
                end
            end else if (req) begin
                s_m = model_slot(addr, n_m);
                if (s_m == 0) begin
                    e_gnt = 1'b1;
                    errn[k] = 1'b1;
                end else begin
                    e_req[s_m] = 1'b1;
                    e_gnt = pgnt[s_m];
                    if (pgnt[s_m]) begin
                        busy[k] = 1'b1; slot_m[k] = s_m; start_m[k] = cyc;
                    end
                end
            end
            tag = $sformatf("n%0d c%0d", n_m, cyc);
            check({tag, " periph_req"}, 64'(a_req), 64'(e_req));
            check({tag, " gnt"},        64'(a_gnt), 64'(e_gnt));
            check({tag, " rvalid"},     64'(a_rv),  64'(e_rv));
            check({tag, " rdata"},      64'(a_rd),  64'(e_rd));
            check({tag, " err"},        64'(a_err), 64'(e_err));
            check({tag, " timeout"},    64'(a_to),  64'(e_to));
            check({tag, " p_addr"},  64'(a_addr), rst ? 64'd0 : 64'(addr));
            check({tag, " p_we"},    64'(a_we),   rst ? 64'd0 : 64'(we));
            check({tag, " p_be"},    64'(a_be),   rst ? 64'd0 : 64'(be));
            check({tag, " p_wdata"}, 64'(a_wd),   rst ? 64'd0 : 64'(wdata));
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; pgnt = '0; prvalid = '0; perr = '0;
    endtask

    logic [31:0] addr_pool [14];
    int          rv_div;

    initial begin
        rst = 1'b1; idle(); addr = 32'h5000; we = 1'b0; be = 4'hF; wdata = '0;
        prdata = '0;

        check("map 0x6010 n7",  64'(model_slot(32'h6010, 7)),  64'd6);
        check("map 0x6010 n6",  64'(model_slot(32'h6010, 6)),  64'd0);
        check("map 0x36ffc",    64'(model_slot(32'h36FFC, 7)), 64'd5);
        check("map 0x37000",    64'(model_slot(32'h37000, 7)), 64'd0);

        // Reset with a request pending: nothing may leak out.
        tick(); req = 1'b1; pgnt = '1;
        @(negedge clk);
        check("rst gnt", 64'(if7.gnt_o), 64'd0);
        check("rst req", 64'(if7.periph_req_o), 64'd0);
        tick(); tick(); rst = 1'b0; idle();

        // BootROM read with immediate grant and next-cycle response.
        tick(); req = 1'b1; addr = 32'h1004; we = 1'b0; pgnt = 7'b0000100;
        @(negedge clk);
        check("d1 periph_req", 64'(if7.periph_req_o), 64'h04);
        check("d1 gnt", 64'(if7.gnt_o), 64'd1);
        tick(); idle(); prvalid = 7'b0000100; prdata[2*32 +: 32] = 32'h1234_5678;
        @(negedge clk);
        check("d1 rvalid", 64'(if7.rvalid_o), 64'd1);
        check("d1 rdata", 64'(if7.rdata_o), 64'h1234_5678);
        check("d1 err", 64'(if7.err_o), 64'd0);

        // Unmapped write.
        tick(); idle(); req = 1'b1; addr = 32'h5000; we = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        check("d2 gnt", 64'(if7.gnt_o), 64'd1);
        check("d2 periph_req", 64'(if7.periph_req_o), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("d2 rvalid", 64'(if7.rvalid_o), 64'd1);
        check("d2 err", 64'(if7.err_o), 64'd1);
        check("d2 rdata", 64'(if7.rdata_o), 64'(ERR_DATA));

        // TB printf slot exists only in the 7-slot build; CoreLocal upper edge.
        tick(); idle(); req = 1'b1; addr = 32'h6010; we = 1'b0; pgnt = 7'b1000000;
        @(negedge clk);
        check("d3 n7 periph_req", 64'(if7.periph_req_o), 64'h40);
        check("d3 n6 periph_req", 64'(if6.periph_req_o), 64'd0);
        check("d3 n6 gnt", 64'(if6.gnt_o), 64'd1);
        tick(); idle(); prvalid = 7'b1000000; prdata[6*32 +: 32] = 32'hCAFE_0006;
        @(negedge clk);
        check("d3 n7 rdata", 64'(if7.rdata_o), 64'hCAFE_0006);
        check("d3 n6 err", 64'(if6.err_o), 64'd1);
        check("d3 n6 rdata", 64'(if6.rdata_o), 64'(ERR_DATA));
        tick(); idle(); req = 1'b1; addr = 32'h3_6FFC; pgnt = 7'b0100000;
        @(negedge clk);
        check("d3 corelocal req", 64'(if6.periph_req_o), 64'h20);
        tick(); idle(); prvalid = 7'b0100000; perr = 7'b0100000;
        prdata[5*32 +: 32] = 32'h0000_0055;
        @(negedge clk);
        check("d3 target err", 64'(if7.err_o), 64'd1);
        check("d3 target rdata", 64'(if7.rdata_o), 64'h55);
        tick(); idle(); req = 1'b1; addr = 32'h3_7000; pgnt = '1;
        @(negedge clk);
        check("d3 0x37000 req", 64'(if7.periph_req_o), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("d3 0x37000 err", 64'(if7.err_o), 64'd1);

        // SocCtrl grants and never answers; late response after the timeout.
        tick(); idle(); req = 1'b1; addr = 32'h0010; pgnt = 7'b0000010;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick(); idle();
        end
        @(negedge clk);
        check("d4 c15 rvalid", 64'(if7.rvalid_o), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("d4 c16 rvalid", 64'(if7.rvalid_o), 64'd1);
        check("d4 c16 timeout", 64'(if7.timeout_o), 64'd1);
        check("d4 c16 rdata", 64'(if7.rdata_o), 64'(ERR_DATA));
        repeat (3) tick();
        tick(); prvalid = 7'b0000010;
        @(negedge clk);
        check("d4 late rvalid", 64'(if7.rvalid_o), 64'd0);

        // Debug withholds its grant; a new request in the response cycle waits.
        tick(); idle(); req = 1'b1; addr = 32'h3000;
        @(negedge clk); check("d5 c0 gnt", 64'(if7.gnt_o), 64'd0);
        tick(); @(negedge clk); check("d5 c1 gnt", 64'(if7.gnt_o), 64'd0);
        tick(); @(negedge clk); check("d5 c2 req", 64'(if7.periph_req_o), 64'h10);
        tick(); pgnt = 7'b0010000;
        @(negedge clk); check("d5 c3 gnt", 64'(if7.gnt_o), 64'd1);
        tick(); pgnt = 7'b0000010; prvalid = 7'b0010000; addr = 32'h0100;
        @(negedge clk);
        check("d5 c4 rvalid", 64'(if7.rvalid_o), 64'd1);
        check("d5 c4 gnt", 64'(if7.gnt_o), 64'd0);
        tick(); prvalid = '0;
        @(negedge clk); check("d5 c5 gnt", 64'(if7.gnt_o), 64'd1);
        tick(); idle(); prvalid = 7'b0000010;

        // Reset while waiting on a target.
        tick(); idle(); req = 1'b1; addr = 32'h2000; pgnt = 7'b0001000;
        tick(); rst = 1'b1; pgnt = '0;
        @(negedge clk);
        check("d6 rst gnt", 64'(if7.gnt_o), 64'd0);
        check("d6 rst addr", 64'(if7.periph_addr_o), 64'd0);
        tick(); rst = 1'b0; idle(); prvalid = 7'b0001000;
        @(negedge clk);
        check("d6 stale rvalid", 64'(if7.rvalid_o), 64'd0);

        // Randomized traffic, with a slow-target stretch to reach timeouts.
        addr_pool = '{32'h0, 32'hFFC, 32'h1000, 32'h1FFC, 32'h2000, 32'h3FFC, 32'h4000,
                      32'h5FFC, 32'h6000, 32'h6FFC, 32'h7000, 32'h3_6FFC, 32'h3_7000,
                      32'hFFFF_FFFC};
        for (int i = 0; i < 4000; i++) begin
            tick();
            rv_div  = (i >= 2000 && i < 3000) ? 40 : 3;
            rst     = ($urandom_range(0, 299) == 0);
            req     = ($urandom_range(0, 2) != 0);
            addr    = ($urandom_range(0, 4) == 0) ? $urandom() : addr_pool[$urandom_range(0, 13)];
            we      = 1'($urandom());
            be      = 4'($urandom());
            wdata   = $urandom();
            pgnt    = 7'($urandom());
            perr    = 7'($urandom());
            for (int j = 0; j < 7; j++) begin
                prvalid[j] = ($urandom_range(0, rv_div - 1) == 0);
                prdata[j*32 +: 32] = $urandom();
            end
        end
        tick(); idle(); rst = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
